// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared types and constants for the alu_exec_ctrl execute
// sequencer. Holds the FSM state enum, the 3-bit ALU op encoding, the
// MIPS funct/opcode constants and the instruction decoder.
// Build option: ALU_EXEC_IMM_EN enables decode of addi (opcode 001000).
package alu_exec_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_RESP} state_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;

  typedef struct packed {
    logic       legal;
    logic [2:0] op;
    logic [4:0] rd;
  } dec_t;

  // Illegal encodings come back with op=AND and rd=0 so the datapath
  // needs no extra muxing for the error case.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.legal = 1'b0;
    d.op    = ALU_AND;
    d.rd    = 5'd0;
    if (instr[31:26] == OPC_RTYPE) begin
      d.legal = 1'b1;
      d.rd    = instr[15:11];
      case (instr[5:0])
        FN_ADD:  d.op = ALU_ADD;
        FN_SUB:  d.op = ALU_SUB;
        FN_AND:  d.op = ALU_AND;
        FN_OR:   d.op = ALU_OR;
        FN_SLT:  d.op = ALU_SLT;
        default: d.legal = 1'b0;
      endcase
    end
`ifdef ALU_EXEC_IMM_EN
    else if (instr[31:26] == OPC_ADDI) begin
      d.legal = 1'b1;
      d.op    = ALU_ADD;
      d.rd    = instr[20:16];
    end
`endif
    if (!d.legal) begin
      d.op = ALU_AND;
      d.rd = 5'd0;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_exec_regfile.sv
// alu_exec_regfile: NREG x W architectural register file.
// Ports: clk_i/rst_i (sync active-high clear of all entries),
//   ra_addr_i/ra_data_o and rb_addr_i/rb_data_o asynchronous reads,
//   we_i/wa_i/wd_i synchronous write. r0 always reads zero and ignores writes.
module alu_exec_regfile #(
  parameter int NREG = 32,
  parameter int W    = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] ra_addr_i,
  output logic [W-1:0]  ra_data_o,
  input  logic [AW-1:0] rb_addr_i,
  output logic [W-1:0]  rb_data_o,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [W-1:0]  wd_i
);

  logic [W-1:0] mem_q [NREG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o = (ra_addr_i == '0) ? '0 : mem_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == '0) ? '0 : mem_q[rb_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: multi-cycle execute sequencer around an external
// combinational ALU. One instruction at a time: IDLE -> READ -> EXEC -> RESP.
// Ports: clk/rst (sync active-high); in_valid/in_ready/in_instr accept side;
//   alu_a/alu_b/alu_op drive the ALU, alu_z/alu_zero return its result;
//   out_valid/out_ready/out_rd/out_result/out_zero/out_err result side.
// Build option: ALU_EXEC_IMM_EN adds addi with a sign-extended immediate.
module alu_exec_ctrl #(
  parameter int NREG = 32,
  parameter int W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_instr,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_z,
  input  logic         alu_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   out_rd,
  output logic [W-1:0] out_result,
  output logic         out_zero,
  output logic         out_err
);
  import alu_exec_pkg::*;

  localparam int AW = $clog2(NREG);

  state_e       state_q, state_d;
  logic [31:0]  instr_q;
  logic [W-1:0] a_q, b_q;
  logic [2:0]   op_q;
  logic [4:0]   dest_q;
  logic         legal_q;
  logic [4:0]   out_rd_q;
  logic [W-1:0] out_result_q;
  logic         out_zero_q, out_err_q;

  logic [W-1:0] ra_data, rb_data, b_sel;
  logic         rf_we;
  dec_t         dec;

  assign dec = decode(instr_q);

`ifdef ALU_EXEC_IMM_EN
  logic         use_imm;
  logic [W-1:0] imm_ext;
  assign use_imm = (instr_q[31:26] == OPC_ADDI);
  assign imm_ext = {{(W-16){instr_q[15]}}, instr_q[15:0]};
  assign b_sel   = use_imm ? imm_ext : rb_data;
`else
  assign b_sel   = rb_data;
`endif

  // rst on the EXEC edge must not commit a write; the regfile clear also
  // wins, but the explicit gate keeps the intent local.
  assign rf_we = (state_q == ST_EXEC) && legal_q && (dest_q != 5'd0) && !rst;

  alu_exec_regfile #(.NREG(NREG), .W(W), .AW(AW)) u_rf (
    .clk_i     (clk),
    .rst_i     (rst),
    .ra_addr_i (instr_q[21 +: AW]),
    .ra_data_o (ra_data),
    .rb_addr_i (instr_q[16 +: AW]),
    .rb_data_o (rb_data),
    .we_i      (rf_we),
    .wa_i      (dest_q[AW-1:0]),
    .wd_i      (alu_z)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_READ;
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand/op registers double as the ALU drive: they change only at the
  // end of READ, so the ALU inputs hold between instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= ALU_AND;
      dest_q       <= '0;
      legal_q      <= 1'b0;
      out_rd_q     <= '0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && in_valid) instr_q <= in_instr;
      if (state_q == ST_READ) begin
        a_q     <= ra_data;
        b_q     <= b_sel;
        op_q    <= dec.op;
        dest_q  <= dec.rd;
        legal_q <= dec.legal;
      end
      if (state_q == ST_EXEC) begin
        out_rd_q     <= dest_q;
        out_result_q <= legal_q ? alu_z : '0;
        out_zero_q   <= alu_zero;
        out_err_q    <= !legal_q;
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign out_rd     = out_rd_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: scoreboard bench for alu_exec_ctrl. A behavioural ALU
// answers the DUT; a reference register-file model predicts each result.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] alu_a, alu_b, alu_z;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic        out_zero, out_err;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.NREG(32), .W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_result(out_result),
    .out_zero(out_zero), .out_err(out_err)
  );

  // Override lets the default build seed registers without addi.
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_z    = ovr_en ? ovr_val : alu_f(alu_a, alu_b, alu_op);
    alu_zero = (alu_z == 32'd0);
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] result;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mrf [32];
  int          checks = 0;
  int          errs   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic mdecode(input logic [31:0] ins, output logic legal, output logic [2:0] op,
                         output logic [4:0] rd, output logic imm);
    legal = 1'b0; op = 3'b000; rd = 5'd0; imm = 1'b0;
    if (ins[31:26] == 6'd0) begin
      rd = ins[15:11];
      legal = 1'b1;
      case (ins[5:0])
        6'h20: op = 3'b010;
        6'h22: op = 3'b110;
        6'h24: op = 3'b000;
        6'h25: op = 3'b001;
        6'h2A: op = 3'b111;
        default: legal = 1'b0;
      endcase
    end
`ifdef ALU_EXEC_IMM_EN
    else if (ins[31:26] == 6'b001000) begin
      legal = 1'b1; op = 3'b010; rd = ins[20:16]; imm = 1'b1;
    end
`endif
    if (!legal) begin op = 3'b000; rd = 5'd0; end
  endtask

  task automatic issue(input logic [31:0] ins, input int hold);
    logic legal, imm;
    logic [2:0] op;
    logic [4:0] rd;
    logic [31:0] a, b, z;
    exp_t e;
    int n;
    mdecode(ins, legal, op, rd, imm);
    a = mrf[ins[25:21]];
    b = imm ? {{16{ins[15]}}, ins[15:0]} : mrf[ins[20:16]];
    z = ovr_en ? ovr_val : alu_f(a, b, op);
    e.rd = rd; e.err = !legal; e.result = legal ? z : 32'd0; e.zero = (z == 32'd0);
    if (legal && rd != 5'd0) mrf[rd] = z;
    sb.push_back(e);

    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_instr = ins; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    chk("exec_op", {29'd0, alu_op}, {29'd0, op});
    if (legal) begin
      chk("exec_a", alu_a, a);
      chk("exec_b", alu_b, b);
    end
    n = 2;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 3);
    if (!out_valid) begin
      void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
      chk("out_result", out_result, e.result);
      chk("out_err", {31'd0, out_err}, {31'd0, e.err});
      if (!e.err) chk("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
      if (h < hold) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_misc", {24'd0, out_rd, out_zero, out_err, 1'b0}, 32'd0);
    chk("rst_alu", alu_a | alu_b | {29'd0, alu_op}, 32'd0);
    @(negedge clk) rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef ALU_EXEC_IMM_EN
    issue(32'h20010005, 0);                  // addi r1,r0,5
    issue(32'h2002FFFD, 0);                  // addi r2,r0,-3
`else
    issue(32'h20010005, 0);                  // addi is illegal here
    ovr_en = 1'b1; ovr_val = 32'h00000005;
    issue(32'h00000825, 0);                  // seed r1
    ovr_val = 32'hFFFFFFFD;
    issue(32'h00001025, 0);                  // seed r2
    ovr_en = 1'b0;
`endif
    issue(32'h00221820, 0);                  // add r3,r1,r2 -> 2
    issue(32'h00212022, 10);                 // sub r4,r1,r1 -> 0, held 10
    issue(32'h0001282A, 0);                  // slt r5,r0,r1 -> 1
    issue(32'h00210020, 0);                  // add r0,r1,r1 -> 10, dropped
    issue(32'h00003025, 0);                  // or r6,r0,r0 -> 0
    issue(32'h00415024, 0);                  // and r10,r2,r1 -> 5
    issue(32'h0041582A, 0);                  // slt r11,r2,r1 -> 1
    issue(32'h00221800, 0);                  // funct 0 -> illegal
    issue(32'h00606025, 3);                  // or r12,r3,r0 -> r3 intact
    issue(32'h20010005, 0);                  // addi / illegal per build
    issue(32'h00206825, 0);                  // or r13,r1,r0
    issue(32'h8C220000, 0);                  // lw -> illegal

    // Reset during EXEC of add r7,r1,r1
    @(negedge clk);
    in_instr = 32'h00213820; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_exec_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk) rst = 1'b0;
    chk("rst_exec_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_exec_out", out_result, 32'd0);
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    sb.delete();
    issue(32'h00E04025, 0);                  // or r8,r7,r0 -> 0
    issue(32'h00214820, 0);                  // add r9,r1,r1 -> 0 after clear

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
